apx_adder_arbiter: RTL

APX_ADDER_ARBITER -- requirements
Module: apx_adder_arbiter

---
 rtl/apx_adder_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/apx_adder_arbiter.sv
// apx_adder_arbiter: round-robin arbiter sharing one external (approximate) adder
// between two requesters; each op is latched, held for LATENCY cycles, then returned.
module apx_adder_arbiter #(
  parameter int unsigned LATENCY  = 1,
  parameter int unsigned ACCURACY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_operand_1,
  input  logic [63:0] req_operand_2,
  input  logic [15:0] req_accuracy,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic [31:0] input_1,
  output logic [31:0] input_2,
  output logic [7:0]  accuracy,
  input  logic [31:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic        r_last_grant;
  logic [3:0]  r_cnt;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [7:0]  r_acc;
  logic [31:0] r_result;

  logic [1:0]  w_grant;
  logic        w_grant_idx;
  logic        w_accept;
  logic        w_resp_done;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    w_grant = '0;
    unique case (req_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = '0;
    endcase
  end

  assign w_grant_idx = w_grant[1];
  assign req_ready   = (r_state == IDLE && !reset) ? w_grant : '0;
  assign w_accept    = |(req_valid & req_ready);
  assign w_resp_done = resp_ready[r_owner];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    if (w_resp_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_acc        <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_accept) begin
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_cnt        <= CNT_LOAD;
        r_op1        <= w_grant_idx ? req_operand_1[63:32] : req_operand_1[31:0];
        r_op2        <= w_grant_idx ? req_operand_2[63:32] : req_operand_2[31:0];
        r_acc        <= w_grant_idx ? req_accuracy[15:8]   : req_accuracy[7:0];
      end
      if (r_state == WAIT) begin
        if (r_cnt == '0) begin
          r_result <= result;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  assign resp_valid  = (r_state == RESP && !reset) ? {r_owner, ~r_owner} : '0;
  assign resp_result = r_result;
  assign input_1     = r_op1;
  assign input_2     = r_op2;
  assign accuracy    = (ACCURACY != 0) ? r_acc : '0;

endmodule
